// File: rtl/imem_boot_loader.sv
// Boot loader feeding the instruction memory write port from a byte stream.
// It assembles big-endian words, verifies an XOR checksum and then releases the CPU.
module imem_boot_loader #(
    parameter int unsigned MAX_WORDS = 256,
    parameter int unsigned TIMEOUT   = 1000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_run,
    output logic        load_err,
    output logic [15:0] words_loaded
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned IDLE_W = 32;

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state, state_d;
    logic [CNT_W-1:0]    len, len_d;
    logic [CNT_W-1:0]    len_rx;
    logic [CNT_W-1:0]    word_idx, word_idx_d;
    logic [1:0]          byte_cnt, byte_cnt_d;
    logic [WORD_W-1:0]   asm_word, asm_word_d;
    logic [BYTE_W-1:0]   chk, chk_d;
    logic [IDLE_W-1:0]   idle_cnt, idle_cnt_d;
    logic                wr_en_d;
    logic [WORD_W-1:0]   wr_addr_d, wr_data_d;
    logic [CNT_W-1:0]    words_loaded_d;
    logic                in_ready_d, cpu_run_d, load_err_d;
    logic                accept, waiting, timed_out;

    // Next-state and datapath update for one clock.
    always_comb begin
        state_d        = state;
        len_d          = len;
        word_idx_d     = word_idx;
        byte_cnt_d     = byte_cnt;
        asm_word_d     = asm_word;
        chk_d          = chk;
        idle_cnt_d     = idle_cnt;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr;
        wr_data_d      = wr_data;
        words_loaded_d = words_loaded;
        len_rx         = {len[15:8], in_data};

        accept    = in_valid && in_ready;
        waiting   = (state == S_LEN_LO) || (state == S_DATA) || (state == S_CHK);
        timed_out = (TIMEOUT != 0) && waiting && !in_valid
                    && ((idle_cnt + IDLE_W'(1)) == TIMEOUT);

        if (accept) begin
            idle_cnt_d = '0;
        end else if (waiting && !in_valid && (TIMEOUT != 0)) begin
            idle_cnt_d = idle_cnt + IDLE_W'(1);
        end

        case (state)
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {in_data, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_rx;
                    if (len_rx == '0) begin
                        state_d = S_CHK;
                    end else if (32'(len_rx) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    asm_word_d = {asm_word[23:0], in_data};
                    chk_d      = chk ^ in_data;
                    byte_cnt_d = byte_cnt + 2'd1;
                    // Fourth byte completes a word: write it at its PC byte address.
                    if (byte_cnt == 2'd3) begin
                        wr_en_d        = 1'b1;
                        wr_data_d      = {asm_word[23:0], in_data};
                        wr_addr_d      = {14'b0, word_idx, 2'b00};
                        words_loaded_d = words_loaded + CNT_W'(1);
                        word_idx_d     = word_idx + CNT_W'(1);
                        if (word_idx == (len - CNT_W'(1))) begin
                            state_d = S_CHK;
                        end
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == chk) ? S_DONE : S_ERR;
                end
            end
            S_DONE: state_d = S_DONE;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        if (timed_out) begin
            state_d = S_ERR;
        end

        in_ready_d = (state_d == S_LEN_HI) || (state_d == S_LEN_LO)
                     || (state_d == S_DATA) || (state_d == S_CHK);
        cpu_run_d  = (state_d == S_DONE);
        load_err_d = (state_d == S_ERR);
    end

    // State and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= S_LEN_HI;
            len          <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
            asm_word     <= '0;
            chk          <= '0;
            idle_cnt     <= '0;
            in_ready     <= 1'b1;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            cpu_run      <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_d;
            len          <= len_d;
            word_idx     <= word_idx_d;
            byte_cnt     <= byte_cnt_d;
            asm_word     <= asm_word_d;
            chk          <= chk_d;
            idle_cnt     <= idle_cnt_d;
            in_ready     <= in_ready_d;
            wr_en        <= wr_en_d;
            wr_addr      <= wr_addr_d;
            wr_data      <= wr_data_d;
            cpu_run      <= cpu_run_d;
            load_err     <= load_err_d;
            words_loaded <= words_loaded_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a vector table of per-cycle expectations
// plus a hand-written asynchronous mid-load reset sequence.
module tb_imem_boot_loader;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_run;
    logic        load_err;
    logic [15:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;

    imem_boot_loader #(.MAX_WORDS(256), .TIMEOUT(8)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_run      (cpu_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       tag;
        logic        rst;
        logic [7:0]  data;
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        run;
        logic        err;
        logic        rdy;
        logic [15:0] wl;
    } vec_t;

    vec_t  vecs[$];
    string cur_tag = "";

    task automatic add(input logic [7:0] d, input logic v, input logic we,
                       input logic [31:0] a, input logic [31:0] wd, input logic run,
                       input logic err, input logic rdy, input logic [15:0] wl);
        vec_t r;
        r.tag = cur_tag; r.rst = 1'b0; r.data = d; r.valid = v;
        r.we = we; r.addr = a; r.wdata = wd; r.run = run; r.err = err; r.rdy = rdy; r.wl = wl;
        vecs.push_back(r);
    endtask

    task automatic add_rst(input string tag);
        cur_tag = tag;
        add(8'h00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd0);
        vecs[vecs.size()-1].rst = 1'b1;
    endtask

    // Byte (or idle cycle) that must leave every output as it was, with no write strobe.
    task automatic add_hold(input logic [7:0] d, input logic v);
        vec_t r;
        r = vecs[vecs.size()-1];
        r.rst = 1'b0; r.data = d; r.valid = v; r.we = 1'b0;
        vecs.push_back(r);
    endtask

    task automatic add_idle();
        add_hold(8'h00, 1'b0);
    endtask

    task automatic cmp(input string name, input string field, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic run, input logic err,
                             input logic rdy, input logic [15:0] wl);
        cmp(name, "wr_en",        32'(wr_en),        32'(we));
        cmp(name, "wr_addr",      wr_addr,           a);
        cmp(name, "wr_data",      wr_data,           wd);
        cmp(name, "cpu_run",      32'(cpu_run),      32'(run));
        cmp(name, "load_err",     32'(load_err),     32'(err));
        cmp(name, "in_ready",     32'(in_ready),     32'(rdy));
        cmp(name, "words_loaded", 32'(words_loaded), 32'(wl));
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge CLK);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #12 RST  = 1'b0;

        // Single word, valid every cycle; CHK byte right after the final byte.
        add_rst("single");
        add_hold(8'h00, 1); add_hold(8'h01, 1);
        add_hold(8'h20, 1); add_hold(8'h08, 1); add_hold(8'h00, 1);
        add(8'h05, 1, 1, 32'h0, 32'h20080005, 0, 0, 1, 16'd1);
        add(8'h2D, 1, 0, 32'h0, 32'h20080005, 1, 0, 0, 16'd1);
        add_hold(8'hAA, 1);

        // Three words with in_valid toggling every other cycle.
        add_rst("three");
        add_hold(8'h00, 1); add_idle(); add_hold(8'h03, 1); add_idle();
        add_hold(8'h8C, 1); add_idle(); add_hold(8'h01, 1); add_idle(); add_hold(8'h00, 1); add_idle();
        add(8'h00, 1, 1, 32'h0, 32'h8C010000, 0, 0, 1, 16'd1); add_idle();
        add_hold(8'h00, 1); add_idle(); add_hold(8'h22, 1); add_idle(); add_hold(8'h18, 1); add_idle();
        add(8'h20, 1, 1, 32'h4, 32'h00221820, 0, 0, 1, 16'd2); add_idle();
        add_hold(8'hAC, 1); add_idle(); add_hold(8'h03, 1); add_idle(); add_hold(8'h00, 1); add_idle();
        add(8'h04, 1, 1, 32'h8, 32'hAC030004, 0, 0, 1, 16'd3); add_idle();
        add(8'h3C, 1, 0, 32'h8, 32'hAC030004, 1, 0, 0, 16'd3);
        add_hold(8'h00, 1);

        // Bad checksum: word still written, then sticky error, later bytes ignored.
        add_rst("badchk");
        add_hold(8'h00, 1); add_hold(8'h01, 1);
        add_hold(8'h20, 1); add_hold(8'h08, 1); add_hold(8'h00, 1);
        add(8'h05, 1, 1, 32'h0, 32'h20080005, 0, 0, 1, 16'd1);
        add(8'h2C, 1, 0, 32'h0, 32'h20080005, 0, 1, 0, 16'd1);
        add_hold(8'h2D, 1); add_hold(8'h11, 1);

        // N=257 is rejected after LEN_LO; four more bytes must not produce a write.
        add_rst("overflow");
        add_hold(8'h01, 1);
        add(8'h01, 1, 0, 32'h0, 32'h0, 0, 1, 0, 16'd0);
        add_hold(8'h20, 1); add_hold(8'h08, 1); add_hold(8'h00, 1); add_hold(8'h05, 1);

        // N=256 (exactly MAX_WORDS) is accepted and loads normally.
        add_rst("n256");
        add_hold(8'h01, 1); add_hold(8'h00, 1);
        add_hold(8'h20, 1); add_hold(8'h08, 1); add_hold(8'h00, 1);
        add(8'h05, 1, 1, 32'h0, 32'h20080005, 0, 0, 1, 16'd1);

        // N=0: only the CHK byte (0x00) follows.
        add_rst("n0");
        add_hold(8'h00, 1); add_hold(8'h00, 1);
        add(8'h00, 1, 0, 32'h0, 32'h0, 1, 0, 0, 16'd0);

        // Timeout: 7 idle cycles tolerated, the 8th triggers the error.
        add_rst("timeout");
        add_hold(8'h00, 1); add_hold(8'h02, 1); add_hold(8'h8C, 1);
        for (int k = 0; k < 7; k++) add_idle();
        add(8'h00, 0, 0, 32'h0, 32'h0, 0, 1, 0, 16'd0);

        // LEN_HI never times out; each accepted byte clears the idle counter.
        add_rst("idleclr");
        for (int k = 0; k < 12; k++) add_idle();
        add_hold(8'h00, 1);
        for (int k = 0; k < 7; k++) add_idle();
        add_hold(8'h01, 1);
        for (int k = 0; k < 7; k++) add_idle();
        add_hold(8'h20, 1);
        for (int k = 0; k < 7; k++) add_idle();
        add(8'h00, 0, 0, 32'h0, 32'h0, 0, 1, 0, 16'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            string name;
            name = $sformatf("%s[%0d]", vecs[i].tag, i);
            if (vecs[i].rst) begin
                @(negedge CLK);
                RST      = 1'b1;
                in_valid = 1'b0;
                in_data  = 8'h00;
                #1;
                check_all(name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].run,
                          vecs[i].err, vecs[i].rdy, vecs[i].wl);
                #1 RST = 1'b0;
            end else begin
                @(negedge CLK);
                in_data  = vecs[i].data;
                in_valid = vecs[i].valid;
                @(posedge CLK);
                #1;
                check_all(name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].run,
                          vecs[i].err, vecs[i].rdy, vecs[i].wl);
            end
        end

        // Asynchronous reset after 5 data bytes, then a fresh frame loads from address 0.
        @(negedge CLK);
        RST = 1'b1; in_valid = 1'b0;
        #2 RST = 1'b0;
        send(8'h00); send(8'h02);
        send(8'h8C); send(8'h01); send(8'h00); send(8'h00);
        check_all("midrst_w0", 1'b1, 32'h0, 32'h8C010000, 1'b0, 1'b0, 1'b1, 16'd1);
        send(8'h00);
        @(negedge CLK);
        in_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        check_all("midrst_async", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 16'd0);
        #1 RST = 1'b0;
        send(8'h00); send(8'h01);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        begin
            int budget;
            budget = 0;
            while (!wr_en && budget < 4) begin
                @(negedge CLK); in_valid = 1'b0;
                @(posedge CLK); #1;
                budget++;
            end
            n_checks++;
            if (!wr_en) begin
                n_fail++;
                $display("FAIL midrst_wait: got wr_en=0 after %0d cycles, expected a write", budget);
            end
        end
        check_all("midrst_w", 1'b1, 32'h0, 32'h20080005, 1'b0, 1'b0, 1'b1, 16'd1);
        send(8'h2D);
        check_all("midrst_done", 1'b0, 32'h0, 32'h20080005, 1'b1, 1'b0, 1'b0, 16'd1);

        in_valid = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the 5-stage pipeline's instruction memory.
- Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit instructions.
- Writes each instruction into the IMem write port at the byte address the PC will later present.
- After a checksum-verified load completes, asserts cpu_run, which gates the PC register and releases the pipeline from address 0.

Parameters:
- MAX_WORDS, 256, largest accepted word count N; larger N is an error.
- TIMEOUT, 1000, idle cycles allowed between bytes once a frame has started; 0 disables the timeout.

Ports:
- CLK  input  1  pipeline clock; all state on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte; a byte transfers on any edge where in_valid&&in_ready.
- wr_en  output  1  one-cycle IMem write strobe.
- wr_addr  output  32  IMem byte address, equal to word_index*4.
- wr_data  output  32  assembled instruction.
- cpu_run  output  1  pipeline/PC enable; sticky once set.
- load_err  output  1  load failed; sticky.
- words_loaded  output  16  count of words written.

Behaviour:
- Reset is asynchronous, active-high. On reset:
  - state=LEN_HI; in_ready=1.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cpu_run=0, load_err=0, words_loaded=0.
  - Internal byte_cnt, len, chk and idle counter cleared.
  - Reset mid-load discards the partial load; the pipeline stays held until a new full frame is accepted.
- Frame format: LEN_HI, LEN_LO (16-bit N, big-endian), then N×4 instruction bytes MSB first, then CHK.
  - CHK = XOR of all instruction bytes only; length bytes are excluded.
- States and transitions (each transition is taken on an accepted byte):
  - LEN_HI -> LEN_LO.
  - LEN_LO:
    - N==0 -> CHK.
    - N>MAX_WORDS -> ERR.
    - else -> DATA.
  - DATA: shift the byte into a 32-bit assembly register and XOR it into chk; byte_cnt increments.
    - On the 4th byte of a word: next cycle wr_en=1 for exactly one cycle, with wr_data=assembled word and wr_addr=word_index*4. words_loaded increments in that same cycle.
    - After word N-1's 4th byte -> CHK.
  - CHK:
    - byte==chk -> DONE.
    - else -> ERR.
  - DONE: cpu_run=1 from the cycle after the CHK byte is accepted; in_ready=0; stays until reset.
  - ERR: load_err=1 from the cycle after the error-causing byte (or timeout); in_ready=0; cpu_run=0; stays until reset.
- in_ready=1 in LEN_HI, LEN_LO, DATA and CHK. The write path is single-cycle, so there is no backpressure.
- Idle counter:
  - Counts cycles with in_valid=0 while in LEN_LO, DATA or CHK; cleared on every accepted byte.
  - Reaching TIMEOUT -> ERR.
  - LEN_HI waits indefinitely.
- in_valid while in_ready=0: ignored; no state change.
- Address arithmetic: word_index is 16-bit. wr_addr = {14'b0, word_index, 2'b00}; no wrap, because N<=MAX_WORDS.
- Simultaneous events: if the byte that completes word N-1 arrives, the FSM enters CHK on that edge while wr_en pulses the next cycle. A CHK byte accepted one cycle later still coexists correctly with that final write.
- wr_data and wr_addr hold their last values when wr_en=0.

Test Plan:
- Single word: stream 00 01 20 08 00 05 2D, valid every cycle.
  - -> one wr_en pulse with wr_addr=0x00000000 and wr_data=0x20080005.
  - -> words_loaded=1.
  - -> cpu_run=1 the cycle after 2D is accepted; in_ready=0.
- Three words: 0x8C010000, 0x00221820, 0xAC030004, with correct chk and in_valid toggled every other cycle.
  - -> writes at addresses 0x0, 0x4, 0x8 with exactly those data.
  - -> cpu_run=1; load_err=0.
- Bad checksum: single-word frame with last byte 2C.
  - -> word still written.
  - -> load_err=1, cpu_run=0, in_ready=0.
  - -> further bytes are ignored.
- Length overflow: with MAX_WORDS=256, send 01 01.
  - -> ERR after LEN_LO.
  - -> no wr_en pulse at any time.
- Timeout: with TIMEOUT=8, send 00 02 8C, then hold in_valid=0 for 8 cycles.
  - -> load_err=1.
  - -> N=0 frame (00 00 00) instead gives cpu_run=1 with words_loaded=0.
- Reset mid-load: assert RST asynchronously after 5 data bytes.
  - -> all outputs return to reset values immediately.
  - -> a complete frame sent afterwards loads from wr_addr=0 and sets cpu_run=1.
